// File: rtl/game_pkg.sv
// game_pkg: shared mode encodings and pixel defaults for the game video path
package game_pkg;
    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_END   = 2'd2
    } mode_t;
    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] TRANSP_KEY = 12'h000;
endpackage

// File: rtl/layer_prio_sel.sv
// layer_prio_sel: lowest-index-first layer pick with background fallback
module layer_prio_sel #(
    parameter int NUM_LAYERS = 8,
    parameter int RGB_W      = 12
) (
    input  logic [NUM_LAYERS-1:0]       en,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    output logic [RGB_W-1:0]            rgb
);
    // walk from the lowest priority upward so the lowest enabled index is applied last
    always_comb begin
        rgb = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            rgb = en[i] ? layer_rgb[i*RGB_W +: RGB_W] : rgb;
    end
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: priority sprite compositing with colour key, hit-flash and title/game/over screens
module layer_compositor #(
    parameter int                NUM_LAYERS   = 8,
    parameter int                RGB_W        = game_pkg::RGB_W,
    parameter bit                KEY_EN       = 1'b1,
    parameter logic [RGB_W-1:0]  TRANSP_KEY   = game_pkg::TRANSP_KEY,
    parameter int                PLAYER_IDX   = 0,
    parameter int                FLASH_FRAMES = 60,
    parameter int                BLINK_BIT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        pix_valid,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [RGB_W-1:0]            start_rgb,
    input  logic [RGB_W-1:0]            end_rgb,
    input  logic                        enter,
    input  logic                        hit,
    input  logic                        dead,
    output logic [RGB_W-1:0]            out_rgb,
    output logic                        out_valid,
    output logic [1:0]                  mode,
    output logic                        flashing
);
    import game_pkg::*;

    mode_t                 mode_q, mode_nxt;
    logic                  pending, pending_nxt, req;
    logic                  enter_q, enter_edge, hide;
    logic [7:0]            flash_cnt;
    logic [NUM_LAYERS-1:0] eff_en;
    logic [RGB_W-1:0]      sel_rgb, s1_rgb;
    logic                  s1_valid;

    assign enter_edge = enter & ~enter_q;
    assign hide       = (flash_cnt != 8'd0) & flash_cnt[BLINK_BIT];
    assign mode       = mode_q;
    assign flashing   = flash_cnt != 8'd0;

    // drop colour-keyed pixels and the player layer while it blinks off
    always_comb begin
        eff_en = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            eff_en[i] = layer_en[i] & ~(KEY_EN & (layer_rgb[i*RGB_W +: RGB_W] == TRANSP_KEY))
                      & ~((i == PLAYER_IDX) & hide);
    end

    layer_prio_sel #(.NUM_LAYERS(NUM_LAYERS), .RGB_W(RGB_W)) u_sel (
        .en        (eff_en),
        .layer_rgb (layer_rgb),
        .bg_rgb    (bg_rgb),
        .rgb       (sel_rgb)
    );

    // latch the mode request and only switch screens at the frame boundary
    always_comb begin
        req         = mode_q == MODE_PLAY ? dead : enter_edge;
        pending_nxt = pending | req;
        mode_nxt    = mode_q;
        if (frame_start && pending_nxt) begin
            pending_nxt = 1'b0;
            mode_nxt    = mode_q == MODE_START ? MODE_PLAY : mode_q == MODE_PLAY ? MODE_END : MODE_START;
        end
    end

    // mode state, pending request and enter history
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_START;
            pending <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            mode_q  <= mode_nxt;
            pending <= pending_nxt;
            enter_q <= enter;
        end
    end

    // hit-flash frame counter, live only while staying in PLAY
    always_ff @(posedge clk) begin
        if (rst || mode_q != MODE_PLAY || mode_nxt != MODE_PLAY)
            flash_cnt <= 8'd0;
        else if (hit)
            flash_cnt <= 8'(FLASH_FRAMES);
        else if (frame_start && flash_cnt != 8'd0)
            flash_cnt <= flash_cnt - 8'd1;
    end

    // two pixel stages: layer pick, then screen-mode substitution
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb    <= '0;
            s1_valid  <= 1'b0;
            out_rgb   <= '0;
            out_valid <= 1'b0;
        end else begin
            s1_rgb    <= sel_rgb;
            s1_valid  <= pix_valid;
            out_rgb   <= !s1_valid ? '0 : mode_q == MODE_START ? start_rgb : mode_q == MODE_END ? end_rgb : s1_rgb;
            out_valid <= s1_valid;
        end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: randomized stimulus against a frame-level behavioural model, plus literal pins
module tb_layer_compositor;
    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [NL-1:0] layer_en = '0;
    logic [NL*12-1:0] layer_rgb = '0;
    logic [11:0]   bg_rgb = '0;
    logic [11:0]   start_rgb = 12'hF00;
    logic [11:0]   end_rgb = 12'hABC;
    logic          enter = 1'b0;
    logic          hit = 1'b0;
    logic          dead = 1'b0;
    logic [11:0]   out_rgb;
    logic          out_valid;
    logic [1:0]    mode;
    logic          flashing;

    layer_compositor dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
        .start_rgb(start_rgb), .end_rgb(end_rgb), .enter(enter), .hit(hit), .dead(dead),
        .out_rgb(out_rgb), .out_valid(out_valid), .mode(mode), .flashing(flashing)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        bit pend;
        int cnt;
        bit enq;
        int s1_rgb;
        bit s1_v;
        int o_rgb;
        bit o_v;
    } st_t;

    st_t m;
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 0;
    bit  pv_hold = 1;
    int  p_rgb = -1, p_v = -1, p_mode = -1, p_fl = -1;

    // next model state from the current one and this cycle's inputs
    function automatic st_t step_model(st_t s);
        st_t n;
        bit  req, hide, found;
        int  pick, c;
        n = s;
        if (rst) begin
            n = '{0, 0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        req    = (s.mode == 1) ? dead : (enter && !s.enq);
        n.enq  = enter;
        n.pend = s.pend || req;
        if (frame_start && n.pend) begin
            n.mode = (s.mode + 1) % 3;
            n.pend = 0;
        end
        if (s.mode != 1 || n.mode != 1) n.cnt = 0;
        else if (hit) n.cnt = 60;
        else if (frame_start && s.cnt > 0) n.cnt = s.cnt - 1;
        hide  = ((s.cnt / 4) % 2) == 1;
        pick  = int'(bg_rgb);
        found = 0;
        for (int i = 0; i < NL; i++) begin
            c = int'(layer_rgb[i*12 +: 12]);
            if (!found && layer_en[i] && c != 0 && !(i == 0 && hide)) begin
                pick  = c;
                found = 1;
            end
        end
        n.s1_rgb = pick;
        n.s1_v   = pix_valid;
        n.o_v    = s.s1_v;
        n.o_rgb  = !s.s1_v ? 0 : s.mode == 0 ? int'(start_rgb) : s.mode == 2 ? int'(end_rgb) : s.s1_rgb;
        return n;
    endfunction

    always @(posedge clk) m <= step_model(m);

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // compare DUT against model every cycle, plus any hand-computed pins
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_rgb", int'(out_rgb), m.o_rgb);
            check("out_valid", int'(out_valid), int'(m.o_v));
            check("mode", int'(mode), m.mode);
            check("flashing", int'(flashing), int'(m.cnt != 0));
            if (p_rgb >= 0) check("pin_rgb", int'(out_rgb), p_rgb);
            if (p_v >= 0) check("pin_valid", int'(out_valid), p_v);
            if (p_mode >= 0) check("pin_mode", int'(mode), p_mode);
            if (p_fl >= 0) check("pin_flashing", int'(flashing), p_fl);
        end
    end

    task automatic set_pin(input int r, input int v, input int md, input int fl);
        p_rgb = r; p_v = v; p_mode = md; p_fl = fl;
    endtask

    task automatic clr_pin();
        set_pin(-1, -1, -1, -1);
    endtask

    function automatic logic [11:0] rgb_rand();
        return ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    endfunction

    task automatic cyc(input bit fs, input bit rnd);
        frame_start = fs;
        if (rnd) begin
            pv_hold  = $urandom_range(0, 7) != 0;
            layer_en = NL'($urandom);
            for (int i = 0; i < NL; i++) layer_rgb[i*12 +: 12] = rgb_rand();
            bg_rgb = 12'($urandom);
        end
        pix_valid = fs ? 1'b0 : pv_hold;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n, input int len, input bit rnd);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < len; c++) cyc(c == 0, rnd);
    endtask

    task automatic pin_cycle(input int r, input int v, input int md, input int fl);
        set_pin(r, v, md, fl);
        cyc(0, 0);
        clr_pin();
    endtask

    int len;

    initial begin
        // reset, title screen colour after two cycles
        rst = 1; pv_hold = 1; start_rgb = 12'hF00;
        cyc(0, 0);
        chk_en = 1;
        set_pin(0, 0, 0, 0);
        rst = 0;
        cyc(0, 0);
        clr_pin();
        cyc(0, 0);
        pin_cycle(12'hF00, 1, 0, 0);

        // enter held mid-frame: one transition at the next frame_start only
        cyc(1, 1);
        for (int i = 0; i < 50; i++) cyc(0, 1);
        enter = 1;
        for (int i = 0; i < 1000; i++) cyc(0, 1);
        set_pin(-1, -1, 0, -1);
        cyc(1, 1);
        clr_pin();
        pin_cycle(-1, -1, 1, -1);
        frames(1, 40, 1);
        pin_cycle(-1, -1, 1, -1);
        enter = 0;

        // priority and colour key in PLAY
        pv_hold = 1; layer_rgb = '0; layer_en = 8'b0000_0110;
        layer_rgb[1*12 +: 12] = 12'h0F0; layer_rgb[2*12 +: 12] = 12'h00F; bg_rgb = 12'h123;
        cyc(0, 0); cyc(0, 0);
        pin_cycle(12'h0F0, 1, 1, 0);
        layer_rgb[1*12 +: 12] = 12'h000;
        cyc(0, 0); cyc(0, 0);
        pin_cycle(12'h00F, 1, 1, 0);
        layer_en = '0; bg_rgb = 12'h5A5;
        cyc(0, 0); cyc(0, 0);
        pin_cycle(12'h5A5, 1, 1, 0);

        // hit-flash blinking, reload and expiry
        layer_rgb = '0; layer_rgb[11:0] = 12'hFFF; layer_en = 8'h01; bg_rgb = 12'h123;
        hit = 1; cyc(0, 0); hit = 0;
        cyc(0, 0); cyc(0, 0);
        pin_cycle(12'h123, 1, 1, 1);
        frames(1, 8, 0);
        pin_cycle(12'hFFF, 1, 1, 1);
        frames(28, 8, 0);
        hit = 1; cyc(0, 0); hit = 0;
        frames(59, 8, 0);
        pin_cycle(-1, -1, 1, 1);
        frames(1, 8, 0);
        pin_cycle(12'hFFF, 1, 1, 0);

        // dead and enter in one PLAY frame -> END, then enter -> START
        dead = 1; cyc(0, 0); cyc(0, 0);
        enter = 1; cyc(0, 0);
        dead = 0; enter = 0; end_rgb = 12'hABC;
        frames(1, 8, 0);
        pin_cycle(12'hABC, 1, 2, 0);
        enter = 1; cyc(0, 0); enter = 0;
        frames(1, 8, 0);
        pin_cycle(12'hF00, 1, 0, 0);

        // invisible pixels, then reset in the middle of a flash
        pv_hold = 0;
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        pin_cycle(0, 0, 0, 0);
        pv_hold = 1;
        enter = 1; cyc(0, 0); enter = 0;
        frames(1, 8, 0);
        hit = 1; cyc(0, 0); hit = 0;
        cyc(0, 0); cyc(0, 0);
        pin_cycle(-1, -1, 1, 1);
        rst = 1; cyc(0, 0);
        set_pin(0, 0, 0, 0);
        rst = 0; cyc(0, 0);
        clr_pin();

        // randomized play
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(6, 24);
            start_rgb = 12'($urandom);
            end_rgb = 12'($urandom);
            for (int c = 0; c < len; c++) begin
                enter = ($urandom_range(0, 5) == 0) ? !enter : enter;
                hit   = $urandom_range(0, 29) == 0;
                dead  = $urandom_range(0, 59) == 0;
                rst   = $urandom_range(0, 299) == 0;
                cyc(c == 0, 1);
            end
        end
        rst = 0; hit = 0; dead = 0; enter = 0;
        cyc(0, 0); cyc(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
